// File: rtl/iomem_pkg.sv
// rtl/iomem_pkg.sv - shared constants and window decode helper for the iomem multiplexer
package iomem_pkg;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_DEAD;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Returns {hit, index}; the subtraction wraps, so windows below base never match.
  function automatic logic [4:0] chan_hit(input logic [15:0] addr_hi,
                                          input logic [15:0] base,
                                          input logic [4:0]  n);
    logic [15:0] diff;
    diff = addr_hi - base;
    return {(diff < {11'd0, n}), diff[3:0]};
  endfunction

endpackage

// File: rtl/iomem_decode.sv
// rtl/iomem_decode.sv - combinational addr[31:16] to one-hot channel hit and index
module iomem_decode
  import iomem_pkg::*;
#(
  parameter int          CHANNELS  = 4,
  parameter logic [15:0] ADDR_BASE = 16'h0300
) (
  input  logic                valid,
  input  logic [15:0]         addr_hi,
  output logic [CHANNELS-1:0] hit,
  output logic [3:0]          idx,
  output logic                any
);

  logic [4:0] res;

  always_comb begin
    hit = '0;
    res = chan_hit(addr_hi, ADDR_BASE, 5'(CHANNELS));
    any = valid && res[4];
    idx = res[3:0];
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = any && (res[3:0] == i[3:0]);
    end
  end

endmodule

// File: rtl/iomem_mux.sv
// rtl/iomem_mux.sv - multi-window iomem slave: strobes one peripheral per access, bounded by a timeout
module iomem_mux
  import iomem_pkg::*;
#(
  parameter int          CHANNELS  = 4,
  parameter logic [15:0] ADDR_BASE = 16'h0300,
  parameter int          TIMEOUT   = 15
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [3:0]             wstrb,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic                   ready,
  output logic [31:0]            rdata,
  output logic [CHANNELS-1:0]    ch_we,
  output logic [CHANNELS-1:0]    ch_re,
  output logic [15:0]            ch_addr,
  output logic [31:0]            ch_wdata,
  output logic [3:0]             ch_wstrb,
  input  logic [32*CHANNELS-1:0] ch_rdata,
  input  logic [CHANNELS-1:0]    ch_ready,
  output logic                   err,
  input  logic                   err_clr
);

  logic [1:0]          state, next_state;
  logic [CHANNELS-1:0] hit;
  logic [3:0]          hit_idx, idx_q;
  logic                hit_any, is_write_q;
  logic [7:0]          cnt;
  logic                sel_ready, timed_out;
  logic [31:0]         sel_rdata;

  iomem_decode #(
    .CHANNELS  (CHANNELS),
    .ADDR_BASE (ADDR_BASE)
  ) u_decode (
    .valid   (valid),
    .addr_hi (addr[31:16]),
    .hit     (hit),
    .idx     (hit_idx),
    .any     (hit_any)
  );

  // Only the latched channel's handshake and data are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx_q == i[3:0]) begin
        sel_ready = ch_ready[i];
        sel_rdata = ch_rdata[32*i +: 32];
      end
    end
  end

  assign timed_out = (cnt == 8'(TIMEOUT));

  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hit_any) next_state = WAIT;
      WAIT:    if (sel_ready || timed_out) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == DONE);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      ch_we      <= '0;
      ch_re      <= '0;
      ch_addr    <= '0;
      ch_wdata   <= '0;
      ch_wstrb   <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      cnt        <= '0;
      idx_q      <= '0;
      is_write_q <= 1'b0;
    end else begin
      ch_we <= '0;
      ch_re <= '0;
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (hit_any) begin
            idx_q      <= hit_idx;
            is_write_q <= |wstrb;
            ch_addr    <= addr[15:0];
            ch_wdata   <= wdata;
            ch_wstrb   <= wstrb;
            cnt        <= '0;
            if (|wstrb) ch_we <= hit;
            else        ch_re <= hit;
          end
        end
        WAIT: begin
          // A handshake in the same cycle as the timeout wins; a timeout set beats err_clr.
          if (sel_ready) begin
            rdata <= is_write_q ? '0 : sel_rdata;
          end else if (timed_out) begin
            rdata <= ERR_DATA;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_mux.sv
// tb/tb_iomem_mux.sv - scoreboard bench for iomem_mux
module tb_iomem_mux;

  localparam int CH = 4;

  logic          ck = 1'b0;
  logic          rst, valid, err_clr;
  logic [3:0]    wstrb;
  logic [31:0]   addr, wdata;
  logic          ready, err;
  logic [31:0]   rdata;
  logic [CH-1:0] ch_we, ch_re, ch_ready;
  logic [15:0]   ch_addr;
  logic [31:0]   ch_wdata;
  logic [3:0]    ch_wstrb;
  logic [32*CH-1:0] ch_rdata;

  int total = 0;
  int bad = 0;
  int ready_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  iomem_mux dut (
    .ck       (ck),
    .rst      (rst),
    .valid    (valid),
    .wstrb    (wstrb),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .ch_we    (ch_we),
    .ch_re    (ch_re),
    .ch_addr  (ch_addr),
    .ch_wdata (ch_wdata),
    .ch_wstrb (ch_wstrb),
    .ch_rdata (ch_rdata),
    .ch_ready (ch_ready),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 ck = ~ck;

  // Scoreboard: every ready pulse pops the oldest expected rdata.
  always @(negedge ck) begin
    if (!rst && ready) begin
      ready_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready rdata=%h", rdata);
      end else begin
        exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
          bad++;
          $display("FAIL rdata got=%h want=%h", rdata, exp_v);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; err_clr = 1'b0; wstrb = '0; addr = '0; wdata = '0;
    ch_ready = '0; ch_rdata = '0;
    repeat (3) @(negedge ck);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
    total++; if (ch_we !== '0 || ch_re !== '0) begin bad++; $display("FAIL rst_strobe got=%b/%b want=0", ch_we, ch_re); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
    total++;
    if (ch_addr !== '0 || ch_wdata !== '0 || ch_wstrb !== '0) begin
      bad++; $display("FAIL rst_latch got=%h/%h/%h want=0", ch_addr, ch_wdata, ch_wstrb);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    @(negedge ck);
    addr = 32'h0302_0010; wdata = 32'h1234_5678; wstrb = 4'hF; ch_ready = 4'b0100; valid = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge ck);
    valid = 1'b0;
    total++; if (ch_we !== 4'b0100) begin bad++; $display("FAIL wr_we got=%b want=0100", ch_we); end
    total++; if (ch_re !== 4'b0000) begin bad++; $display("FAIL wr_re got=%b want=0000", ch_re); end
    total++; if (ch_addr !== 16'h0010) begin bad++; $display("FAIL wr_addr got=%h want=0010", ch_addr); end
    total++; if (ch_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_wdata got=%h want=12345678", ch_wdata); end
    total++; if (ch_wstrb !== 4'hF) begin bad++; $display("FAIL wr_wstrb got=%h want=f", ch_wstrb); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL wr_ready_c1 got=%b want=0", ready); end
    @(negedge ck);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL wr_ready_c2 got=%b want=1", ready); end
    total++; if (ch_we !== 4'b0000) begin bad++; $display("FAIL wr_we_c2 got=%b want=0000", ch_we); end
    ch_ready = '0;
    @(negedge ck);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL wr_ready_c3 got=%b want=0", ready); end
  endtask

  task automatic test_read();
    @(negedge ck);
    ch_rdata[32*1 +: 32] = 32'hCAFE_F00D;
    addr = 32'h0301_0004; wstrb = 4'h0; ch_ready = '0; valid = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    @(negedge ck);
    valid = 1'b0;
    total++; if (ch_re !== 4'b0010) begin bad++; $display("FAIL rd_re got=%b want=0010", ch_re); end
    total++; if (ch_we !== 4'b0000) begin bad++; $display("FAIL rd_we got=%b want=0000", ch_we); end
    @(negedge ck);
    total++; if (ch_re !== 4'b0000) begin bad++; $display("FAIL rd_re_c2 got=%b want=0000", ch_re); end
    @(negedge ck);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rd_ready_c3 got=%b want=0", ready); end
    @(negedge ck);
    total++; if (ch_addr !== 16'h0004) begin bad++; $display("FAIL rd_addr_hold got=%h want=0004", ch_addr); end
    ch_ready = 4'b0010;
    @(negedge ck);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rd_ready_c5 got=%b want=1", ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", err); end
    ch_ready = '0;
  endtask

  task automatic test_timeout();
    int lat;
    @(negedge ck);
    addr = 32'h0303_0000; wstrb = 4'h0; ch_ready = '0; valid = 1'b1;
    exp_q.push_back(32'hDEAD_DEAD);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge ck);
      if (c == 1) valid = 1'b0;
      if (ready) begin lat = c; break; end
    end
    total++; if (lat != 17) begin bad++; $display("FAIL to_latency got=%0d want=17", lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err); end
    err_clr = 1'b1;
    @(negedge ck);
    err_clr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_clr got=%b want=0", err); end
  endtask

  task automatic test_miss();
    int hits;
    for (int a = 0; a < 2; a++) begin
      @(negedge ck);
      addr = (a == 0) ? 32'h0304_0000 : 32'h0400_0000;
      wstrb = 4'hF; ch_ready = 4'hF; valid = 1'b1;
      hits = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge ck);
        if (ready || (|ch_we) || (|ch_re)) hits++;
      end
      valid = 1'b0;
      total++; if (hits != 0) begin bad++; $display("FAIL miss_%0d activity got=%0d want=0", a, hits); end
    end
    ch_ready = '0;
  endtask

  task automatic test_rst_in_wait();
    int lat;
    @(negedge ck);
    addr = 32'h0303_0000; wstrb = 4'h0; ch_ready = '0; valid = 1'b1;
    exp_q.push_back(32'hDEAD_DEAD);
    for (int c = 1; c <= 40; c++) begin
      @(negedge ck);
      if (c == 1) valid = 1'b0;
      if (ready) break;
    end
    @(negedge ck);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rw_err_pre got=%b want=1", err); end
    addr = 32'h0300_0000; wstrb = 4'h0; valid = 1'b1;
    @(negedge ck);
    valid = 1'b0;
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rw_ready got=%b want=0", ready); end
    total++; if (ch_we !== '0 || ch_re !== '0) begin bad++; $display("FAIL rw_strobe got=%b/%b want=0", ch_we, ch_re); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rw_err got=%b want=0", err); end
    addr = 32'h0300_0008; wdata = 32'hA5A5_0001; wstrb = 4'h3; ch_ready = 4'b0001; valid = 1'b1;
    exp_q.push_back(32'h0);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge ck);
      if (c == 1) begin
        valid = 1'b0;
        total++; if (ch_we !== 4'b0001) begin bad++; $display("FAIL rw_next_we got=%b want=0001", ch_we); end
      end
      if (ready) begin lat = c; break; end
    end
    total++; if (lat != 2) begin bad++; $display("FAIL rw_next_latency got=%0d want=2", lat); end
    ch_ready = '0;
  endtask

  task automatic test_foreign_ready();
    @(negedge ck);
    ch_rdata[32*0 +: 32] = 32'h0000_00AA;
    ch_rdata[32*2 +: 32] = 32'h2222_0002;
    addr = 32'h0302_0000; wstrb = 4'h0; ch_ready = 4'b0001; valid = 1'b1;
    exp_q.push_back(32'h2222_0002);
    @(negedge ck);
    valid = 1'b0;
    total++; if (ch_re !== 4'b0100) begin bad++; $display("FAIL fr_re got=%b want=0100", ch_re); end
    @(negedge ck);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL fr_ready_c2 got=%b want=0", ready); end
    @(negedge ck);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL fr_ready_c3 got=%b want=0", ready); end
    ch_ready = 4'b0101;
    @(negedge ck);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL fr_ready_c4 got=%b want=1", ready); end
    ch_ready = '0;
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [15:0] mask;
    @(negedge ck);
    ch_rdata[32*1 +: 32] = 32'h1111_0001;
    addr = 32'h0301_0000; wstrb = 4'h0; ch_ready = 4'hF; valid = 1'b1;
    repeat (4) exp_q.push_back(32'h1111_0001);
    pulses = 0;
    mask = '0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge ck);
      if (c == 12) valid = 1'b0;
      if (ready) begin pulses++; mask[c] = 1'b1; end
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL b2b_pulses got=%0d want=4", pulses); end
    total++; if (mask !== 16'h0924) begin bad++; $display("FAIL b2b_cycles got=%h want=0924", mask); end
    ch_ready = '0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_miss();
    test_rst_in_wait();
    test_foreign_ready();
    test_back_to_back();
    repeat (4) @(negedge ck);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    total++;
    if (ready_seen != 10) begin
      bad++; $display("FAIL ready_count got=%0d want=10", ready_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
